// File: rtl/sseg_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM state encoding
// and digit geometry.
package sseg_pkg;

    typedef logic [0:0] state_t;

    localparam state_t S_SHOW = 1'b0;
    localparam state_t S_GAP  = 1'b1;

    localparam int MAX_DIGITS = 8;
    localparam int DIGIT_W    = 4;

endpackage

// File: rtl/sseg_scan_ctrl_scan_timer.sv
// Scan sequencer: walks each digit through a lit slot and a dark gap, and
// flags the last gap cycle of the last digit as the frame wrap.
module scan_timer
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYC     = 50
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [$clog2(NUM_DIGITS)-1:0] idx,
    output logic                          show,
    output logic                          frame_wrap
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0] idx_r, idx_nxt_s;

    // Next-state logic for the show/gap sequencing and digit index.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CNT_W'(1);
        idx_nxt_s   = idx_r;
        case (state_r)
            S_SHOW: begin
                if (cnt_r == SHOW_LAST) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = S_GAP;
                end else begin
                    state_nxt_s = S_SHOW;
                end
            end
            S_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = S_SHOW;
                    // Explicit wrap so non-power-of-two digit counts work.
                    if (idx_r == IDX_LAST) begin
                        idx_nxt_s = {IDX_W{1'b0}};
                    end else begin
                        idx_nxt_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_nxt_s = S_GAP;
                end
            end
            default: begin
                state_nxt_s = S_SHOW;
                cnt_nxt_s   = {CNT_W{1'b0}};
                idx_nxt_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_SHOW;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    assign idx        = idx_r;
    assign show       = (state_r == S_SHOW);
    assign frame_wrap = (state_r == S_GAP) && (cnt_r == GAP_LAST) && (idx_r == IDX_LAST);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered display image,
// leading-zero blanking and registered decoder/anode drive.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYC     = 50
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         en_in,
    input  logic                          blank_lz,
    output logic [DIGIT_W-1:0]            so_gma,
    output logic                          ena,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_done,
    output logic                          upd_pending
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] pend_dig_r, act_dig_r;
    logic [NUM_DIGITS-1:0]              pend_dp_r, pend_en_r, act_dp_r, act_en_r;
    logic [NUM_DIGITS-1:0]              lz_blank_s, sel_s;
    logic [IDX_W-1:0]                   idx_s;
    logic                               show_s, frame_wrap_s, zero_run_s;

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .GAP_CYC    (GAP_CYC)
    ) u_scan_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (idx_s),
        .show      (show_s),
        .frame_wrap(frame_wrap_s)
    );

    assign sel_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_s;

    // Leading-zero mask: a digit is blanked while it and every higher digit are zero.
    always_comb begin
        lz_blank_s = {NUM_DIGITS{1'b0}};
        zero_run_s = blank_lz;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run_s    = zero_run_s & (act_dig_r[i] == {DIGIT_W{1'b0}});
            lz_blank_s[i] = zero_run_s;
        end
    end

    // Pending/active buffers; the active image only changes at the frame wrap,
    // and a load on that same edge lands in pending and keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_dig_r  <= '0;
            pend_dp_r   <= {NUM_DIGITS{1'b0}};
            pend_en_r   <= {NUM_DIGITS{1'b0}};
            act_dig_r   <= '0;
            act_dp_r    <= {NUM_DIGITS{1'b0}};
            act_en_r    <= {NUM_DIGITS{1'b0}};
            upd_pending <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            if (load) begin
                pend_dig_r <= digits_in;
                pend_dp_r  <= dp_in;
                pend_en_r  <= en_in;
            end
            if (frame_wrap_s && upd_pending) begin
                act_dig_r <= pend_dig_r;
                act_dp_r  <= pend_dp_r;
                act_en_r  <= pend_en_r;
            end
            if (load) begin
                upd_pending <= 1'b1;
            end else if (frame_wrap_s) begin
                upd_pending <= 1'b0;
            end
            frame_done <= frame_wrap_s;
        end
    end

    // Decoder and anode drive, one cycle behind the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            so_gma <= {DIGIT_W{1'b0}};
            ena    <= 1'b0;
            dp     <= 1'b0;
            an     <= {NUM_DIGITS{1'b0}};
        end else if (show_s) begin
            so_gma <= act_dig_r[idx_s];
            ena    <= act_en_r[idx_s] & ~lz_blank_s[idx_s];
            dp     <= act_dp_r[idx_s];
            an     <= sel_s;
        end else begin
            ena <= 1'b0;
            dp  <= 1'b0;
            an  <= {NUM_DIGITS{1'b0}};
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl: cycle-position reference model,
// table-driven display patterns, handshake corner cases and random loads.
module tb_sseg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int GC    = 2;
    localparam int SLOT  = RD + GC;
    localparam int FRAME = SLOT * ND;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in, en_in;
    logic        blank_lz;
    logic [3:0]  so_gma;
    logic        ena, dp;
    logic [3:0]  an;
    logic        frame_done, upd_pending;

    sseg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GAP_CYC(GC)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .en_in(en_in), .blank_lz(blank_lz), .so_gma(so_gma),
        .ena(ena), .dp(dp), .an(an), .frame_done(frame_done),
        .upd_pending(upd_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: display image buffers plus edge count since reset release.
    logic [15:0] m_dig, m_pdig;
    logic [3:0]  m_dp, m_en, m_pdp, m_pen;
    logic        m_upd;
    logic [3:0]  e_an, e_so;
    logic        e_ena, e_dp, e_fd;
    int          k;
    logic        watch_one, saw_one;

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  dpv;
        logic [3:0]  env;
        logic        blz;
        logic [15:0] x_so;
        logic [3:0]  x_ena;
        logic [3:0]  x_dp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_zero();
        m_dig = '0; m_pdig = '0; m_dp = '0; m_en = '0; m_pdp = '0; m_pen = '0;
        m_upd = 1'b0; e_an = '0; e_so = '0; e_ena = 1'b0; e_dp = 1'b0; e_fd = 1'b0;
        k = 0;
    endtask

    task automatic model_edge();
        int  p, s, w;
        logic wrap;
        p = k % FRAME;
        s = p / SLOT;
        w = p % SLOT;
        wrap = (p == FRAME - 1);
        if (w < RD) begin
            e_an  = 4'(1 << s);
            e_so  = m_dig[4*s +: 4];
            e_dp  = m_dp[s];
            e_ena = m_en[s] & !(blank_lz && (s > 0) && ((m_dig >> (4*s)) == 16'h0000));
        end else begin
            e_an  = 4'h0;
            e_ena = 1'b0;
            e_dp  = 1'b0;
        end
        e_fd = wrap;
        if (wrap && m_upd) begin
            m_dig = m_pdig; m_dp = m_pdp; m_en = m_pen;
        end
        if (load) begin
            m_pdig = digits_in; m_pdp = dp_in; m_pen = en_in; m_upd = 1'b1;
        end else if (wrap) begin
            m_upd = 1'b0;
        end
        k++;
    endtask

    task automatic cycle(input logic ld);
        load = ld;
        @(posedge clk);
        model_edge();
        #1;
        chk("cyc", {20'h0, an, so_gma, ena, dp, frame_done, upd_pending},
                   {20'h0, e_an, e_so, e_ena, e_dp, e_fd, m_upd});
        if (watch_one && so_gma == 4'h1) saw_one = 1'b1;
        load = 1'b0;
    endtask

    task automatic set_in(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] env);
        digits_in = d; dp_in = dpv; en_in = env;
    endtask

    task automatic run_to(input int pt);
        while (k % FRAME != pt) cycle(1'b0);
    endtask

    task automatic capture_frame(output logic [15:0] so_c, output logic [3:0] ena_c,
                                 output logic [3:0] dp_c);
        so_c = '0; ena_c = '0; dp_c = '0;
        run_to(0);
        for (int i = 0; i < FRAME; i++) begin
            cycle(1'b0);
            if (i % SLOT == 0) begin
                so_c[4*(i/SLOT) +: 4] = so_gma;
                ena_c[i/SLOT]         = ena;
                dp_c[i/SLOT]          = dp;
            end
        end
    endtask

    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1 chk("async_rst", {20'h0, an, so_gma, ena, dp, frame_done, upd_pending}, 32'h0);
        model_zero();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] so_c;
        logic [3:0]  ena_c, dp_c;

        tbl[0] = '{16'h1A3F, 4'b0100, 4'hF,    1'b0, 16'h1A3F, 4'b1111, 4'b0100};
        tbl[1] = '{16'h0050, 4'b0000, 4'hF,    1'b1, 16'h0050, 4'b0011, 4'b0000};
        tbl[2] = '{16'h0050, 4'b0000, 4'hF,    1'b0, 16'h0050, 4'b1111, 4'b0000};
        tbl[3] = '{16'h0000, 4'b1000, 4'hF,    1'b1, 16'h0000, 4'b0001, 4'b1000};
        tbl[4] = '{16'h0307, 4'b0010, 4'b1010, 1'b1, 16'h0307, 4'b0010, 4'b0010};
        tbl[5] = '{16'h8000, 4'b0000, 4'b0111, 1'b1, 16'h8000, 4'b0111, 4'b0000};

        rst_n = 1'b0; load = 1'b0; blank_lz = 1'b0; watch_one = 1'b0; saw_one = 1'b0;
        set_in(16'h0, 4'h0, 4'h0);
        model_zero();
        repeat (2) @(posedge clk);
        #1 chk("reset_state", {20'h0, an, so_gma, ena, dp, frame_done, upd_pending}, 32'h0);
        #2 rst_n = 1'b1;

        // Free-running scan with an empty image.
        for (int i = 1; i <= 30; i++) begin
            cycle(1'b0);
            if (i == 1)  chk("t1_an1", {28'h0, an}, 32'h1);
            if (i == 5)  chk("t1_gap", {28'h0, an}, 32'h0);
            if (i == 7)  chk("t1_an2", {28'h0, an}, 32'h2);
            if (i == 13) chk("t1_an4", {28'h0, an}, 32'h4);
            if (i == 19) chk("t1_an8", {28'h0, an}, 32'h8);
            if (i == 23) chk("t1_fd_lo", {31'h0, frame_done}, 32'h0);
            if (i == 24) chk("t1_fd_hi", {31'h0, frame_done}, 32'h1);
            chk("t1_dark", {31'h0, ena}, 32'h0);
        end

        // Table-driven display patterns.
        foreach (tbl[n]) begin
            run_to(0);
            blank_lz = tbl[n].blz;
            set_in(tbl[n].dig, tbl[n].dpv, tbl[n].env);
            cycle(1'b1);
            chk("tbl_pend", {31'h0, upd_pending}, 32'h1);
            capture_frame(so_c, ena_c, dp_c);
            chk("tbl_so",  {16'h0, so_c},  {16'h0, tbl[n].x_so});
            chk("tbl_ena", {28'h0, ena_c}, {28'h0, tbl[n].x_ena});
            chk("tbl_dp",  {28'h0, dp_c},  {28'h0, tbl[n].x_dp});
            chk("tbl_pend_clr", {31'h0, upd_pending}, 32'h0);
        end

        // Two loads in one frame: the last one wins.
        blank_lz = 1'b0;
        run_to(0);
        set_in(16'h1111, 4'h0, 4'hF);
        cycle(1'b1);
        run_to(10);
        set_in(16'h2222, 4'h0, 4'hF);
        watch_one = 1'b1;
        cycle(1'b1);
        capture_frame(so_c, ena_c, dp_c);
        watch_one = 1'b0;
        chk("lastwin_so", {16'h0, so_c}, 32'h2222);
        chk("lastwin_no1111", {31'h0, saw_one}, 32'h0);

        // Load on the wrap edge: old pending goes active, new stays pending.
        run_to(0);
        set_in(16'h1234, 4'h0, 4'hF);
        cycle(1'b1);
        run_to(FRAME - 1);
        set_in(16'h5678, 4'h0, 4'hF);
        cycle(1'b1);
        chk("coinc_pend", {31'h0, upd_pending}, 32'h1);
        capture_frame(so_c, ena_c, dp_c);
        chk("coinc_f1", {16'h0, so_c}, 32'h1234);
        capture_frame(so_c, ena_c, dp_c);
        chk("coinc_f2", {16'h0, so_c}, 32'h5678);
        chk("coinc_pend_clr", {31'h0, upd_pending}, 32'h0);

        // Randomized loads and blanking changes against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 7) == 0) begin
                logic [15:0] d;
                d = 16'($urandom);
                for (int j = 0; j < 4; j++) if ($urandom_range(0, 1) == 0) d[4*j +: 4] = 4'h0;
                set_in(d, 4'($urandom), 4'($urandom));
                cycle(1'b1);
            end else begin
                cycle(1'b0);
            end
        end

        // Asynchronous reset while digit 2 is lit.
        blank_lz = 1'b0;
        set_in(16'h9ABC, 4'hF, 4'hF);
        run_to(0);
        cycle(1'b1);
        run_to(0);
        run_to(14);
        chk("pre_rst_an", {28'h0, an}, 32'h4);
        async_reset();
        cycle(1'b0);
        cycle(1'b0);
        chk("rst_an_restart", {28'h0, an}, 32'h1);
        capture_frame(so_c, ena_c, dp_c);
        chk("rst_act_so",  {16'h0, so_c},  32'h0);
        chk("rst_act_ena", {28'h0, ena_c}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
